bfly_r2_pipe: RTL and testbench
===============================

Name: bfly_r2_pipe

Overview:
- Parametrised, pipelined radix-2 complex butterfly; successor to the fixed 8-bit `complex_butterfly`.
- Computes A' = A + B·W and B' = A − B·W on signed fixed-point complex samples.
- Adds a valid/ready handshake with backpressure, a forward/inverse (conjugate-twiddle) mode, optional 1-bit stage scaling, rounding, saturation and a sticky overflow flag.
- Sits between the sample buffer and the next FFT stage; instances chain stage to stage.

Parameters:
- DATA_W, 8, width of each real/imag sample component (signed).
- TW_W, 8, width of each twiddle component (signed, Q1.(TW_W-1)).
- SCALE, 0, 1 = arithmetic right shift by 1 of both outputs (per-stage scaling); 0 = no scaling.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- inverse  in  1  sampled with the beat; 1 = use conj(W).
- a_re, a_im, b_re, b_im  in  DATA_W each  input samples.
- w_re, w_im  in  TW_W each  twiddle.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- ao_re, ao_im, bo_re, bo_im  out  DATA_W each  butterfly results.
- ovf  out  1  sticky saturation flag.
- ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Reset (rst_ low, asynchronous): all pipeline valid bits, data registers, outputs and ovf go to 0 immediately. Any in-flight beats are discarded.
- Handshake:
  - A beat transfers in when in_valid && in_ready, and out when out_valid && out_ready.
  - Global stall: en = !out_valid || out_ready; in_ready = en.
  - While stalled, every stage register holds, so outputs stay stable and no beat is lost or duplicated.
  - Bubbles are not compressed.
- Latency: 3 cycles from input acceptance to out_valid when unstalled. Throughput: 1 beat per cycle.
- Stage 1 registers:
  - The four products br·wr, bi·wi, br·wi, bi·wr, each DATA_W+TW_W signed.
  - A, delayed alongside.
  - inverse.
- Stage 2 sums each product pair at width DATA_W+TW_W+1:
  - forward: t_re = br·wr − bi·wi; t_im = br·wi + bi·wr.
  - inverse: t_re = br·wr + bi·wi; t_im = bi·wr − br·wi.
  - Rounding: add 2^(TW_W-2), then arithmetic shift right by TW_W-1 (round half up). Result width DATA_W+2.
- Stage 3:
  - s = a + t and d = a − t, each at DATA_W+2.
  - If SCALE=1: arithmetic shift right by 1 (floor).
  - Saturate to [−2^(DATA_W-1), 2^(DATA_W-1)−1] and register to the outputs.
- ovf: set when any of the four stage-3 results saturates on a register load with a valid beat. Cleared by ovf_clr. A simultaneous set and clear leaves ovf = 1.
- inverse travels with its beat; mixing modes beat-to-beat is legal.
- Twiddle −1 (0x80 at TW_W=8) is legal; the internal widths cover the worst case without wrap.

Decomposition:
- Package bfly_pkg holds:
  - derived widths: PROD_W = DATA_W+TW_W, SUM_W = PROD_W+1, OUT_INT_W = DATA_W+2.
  - the rounding constant.
  - a saturation function.
- Sub-module cmult_pipe implements stages 1–2: the complex multiply with conjugate select and rounding, with its own stall enable.
- bfly_r2_pipe wraps cmult_pipe and adds the A delay line, the add/sub/scale/saturate stage, the valid chain, the handshake and ovf.

Test Plan (DATA_W=TW_W=8; values shown as re, im):
- Forward, SCALE=0: a=(0x40,0), b=(0x20,0), w=(0x7F,0).
  - Expect ao=(0x60,0x00), bo=(0x20,0x00) exactly 3 cycles after acceptance; ovf=0.
- Forward, twiddle −j: a=(0,0), b=(0x10,0), w=(0x00,0x80).
  - Expect ao=(0x00,0xF0), bo=(0x00,0x10).
  - Same beat with inverse=1: expect ao=(0x00,0x10), bo=(0x00,0xF0).
- Saturation: a=b=(0x7F,0), w=(0x7F,0).
  - SCALE=0: expect ao=(0x7F,0), bo=(0x01,0), ovf=1. ovf stays 1 until an ovf_clr pulse returns it to 0.
  - SCALE=1: expect ao=(0x7E,0), bo=(0x00,0), ovf=0.
- Backpressure: stream 6 consecutive beats with distinct a_re=1..6 while out_ready is held low for 4 cycles mid-stream.
  - Expect in_ready low during the stall and outputs held stable.
  - Expect all 6 results emitted in order, with none dropped or duplicated.
- Reset mid-operation: with 2 beats in flight and ovf=1, pulse rst_ low asynchronously, between clock edges.
  - Expect out_valid=0, all outputs 0 and ovf=0 immediately.
  - After release, the next beat returns after 3 cycles.

Source files
------------

// File: rtl/bfly_pkg.sv
// Shared widths, rounding constant and saturation helpers for the radix-2 butterfly.
// Widths are functions of the instance parameters so one package serves every instance.
package bfly_pkg;

    localparam int SAT_MAX_W = 64;
    localparam logic signed [SAT_MAX_W-1:0] ONE64 = 64'sd1;

    function automatic int prod_w(input int data_w, input int tw_w);
        return data_w + tw_w;
    endfunction

    function automatic int sum_w(input int data_w, input int tw_w);
        return data_w + tw_w + 1;
    endfunction

    function automatic int out_int_w(input int data_w);
        return data_w + 2;
    endfunction

    // Half an LSB of the Q1.(TW_W-1) product scale: rounds half up before the shift.
    function automatic logic signed [SAT_MAX_W-1:0] rnd_const(input int tw_w);
        return ONE64 <<< (tw_w - 2);
    endfunction

    function automatic logic signed [SAT_MAX_W-1:0] sat_clip(
        input logic signed [SAT_MAX_W-1:0] x,
        input int                          data_w
    );
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        hi = (ONE64 <<< (data_w - 1)) - ONE64;
        lo = -(ONE64 <<< (data_w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/bfly_r2_pipe_cmult.sv
// Two-stage complex multiply B*W (or B*conj(W)) with round-half-up back to sample scale.
// Stage 1 registers the four partial products, stage 2 the rounded real/imag sums.
module cmult_pipe
    import bfly_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int TW_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     i_en,
    input  logic                     i_inverse,
    input  logic signed [DATA_W-1:0] i_b_re,
    input  logic signed [DATA_W-1:0] i_b_im,
    input  logic signed [TW_W-1:0]   i_w_re,
    input  logic signed [TW_W-1:0]   i_w_im,
    output logic signed [DATA_W+1:0] o_t_re,
    output logic signed [DATA_W+1:0] o_t_im
);

    localparam int PROD_W    = prod_w(DATA_W, TW_W);
    localparam int SUM_W     = sum_w(DATA_W, TW_W);
    localparam int OUT_INT_W = out_int_w(DATA_W);
    localparam logic signed [SUM_W-1:0] RND = SUM_W'(rnd_const(TW_W));

    logic signed [PROD_W-1:0] r_p_rr;
    logic signed [PROD_W-1:0] r_p_ii;
    logic signed [PROD_W-1:0] r_p_ri;
    logic signed [PROD_W-1:0] r_p_ir;
    logic                     r_inv;

    logic signed [SUM_W-1:0]  w_sum_re;
    logic signed [SUM_W-1:0]  w_sum_im;
    logic signed [SUM_W-1:0]  w_rnd_re;
    logic signed [SUM_W-1:0]  w_rnd_im;

    logic signed [OUT_INT_W-1:0] r_t_re;
    logic signed [OUT_INT_W-1:0] r_t_im;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_p_rr <= '0;
            r_p_ii <= '0;
            r_p_ri <= '0;
            r_p_ir <= '0;
            r_inv  <= 1'b0;
        end else if (i_en) begin
            r_p_rr <= PROD_W'(i_b_re) * PROD_W'(i_w_re);
            r_p_ii <= PROD_W'(i_b_im) * PROD_W'(i_w_im);
            r_p_ri <= PROD_W'(i_b_re) * PROD_W'(i_w_im);
            r_p_ir <= PROD_W'(i_b_im) * PROD_W'(i_w_re);
            r_inv  <= i_inverse;
        end
    end

    // Conjugating W flips the sign of w_im, which swaps the signs of the cross terms.
    always_comb begin
        w_sum_re = '0;
        w_sum_im = '0;
        if (r_inv) begin
            w_sum_re = SUM_W'(r_p_rr) + SUM_W'(r_p_ii);
            w_sum_im = SUM_W'(r_p_ir) - SUM_W'(r_p_ri);
        end else begin
            w_sum_re = SUM_W'(r_p_rr) - SUM_W'(r_p_ii);
            w_sum_im = SUM_W'(r_p_ri) + SUM_W'(r_p_ir);
        end
        w_rnd_re = w_sum_re + RND;
        w_rnd_im = w_sum_im + RND;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_t_re <= '0;
            r_t_im <= '0;
        end else if (i_en) begin
            r_t_re <= OUT_INT_W'(w_rnd_re >>> (TW_W - 1));
            r_t_im <= OUT_INT_W'(w_rnd_im >>> (TW_W - 1));
        end
    end

    assign o_t_re = r_t_re;
    assign o_t_im = r_t_im;

endmodule

// File: rtl/bfly_r2_pipe.sv
// Pipelined radix-2 butterfly: A' = A + B*W, B' = A - B*W, with optional 1-bit scaling,
// saturation to DATA_W and a sticky overflow flag. Three register stages, one beat per cycle.
module bfly_r2_pipe
    import bfly_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int TW_W   = 8,
    parameter int SCALE  = 0
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     inverse,
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    input  logic signed [TW_W-1:0]   w_re,
    input  logic signed [TW_W-1:0]   w_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] ao_re,
    output logic signed [DATA_W-1:0] ao_im,
    output logic signed [DATA_W-1:0] bo_re,
    output logic signed [DATA_W-1:0] bo_im,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int OUT_INT_W = out_int_w(DATA_W);

    // Handshake: a beat moves in on in_valid && in_ready and out on out_valid && out_ready.
    // The whole pipe advances only when the output slot is empty or being drained, so a
    // stall freezes every stage and in_ready follows the same enable.
    logic w_en;
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    logic r_v1;
    logic r_v2;
    logic r_out_valid;

    logic signed [DATA_W-1:0] r_a1_re;
    logic signed [DATA_W-1:0] r_a1_im;
    logic signed [DATA_W-1:0] r_a2_re;
    logic signed [DATA_W-1:0] r_a2_im;

    logic signed [OUT_INT_W-1:0] w_t_re;
    logic signed [OUT_INT_W-1:0] w_t_im;

    logic signed [OUT_INT_W-1:0] w_res  [4];
    logic signed [SAT_MAX_W-1:0] w_wide [4];
    logic signed [DATA_W-1:0]    w_clip [4];
    logic [3:0]                  w_hit;

    logic signed [DATA_W-1:0] r_ao_re;
    logic signed [DATA_W-1:0] r_ao_im;
    logic signed [DATA_W-1:0] r_bo_re;
    logic signed [DATA_W-1:0] r_bo_im;
    logic                     r_ovf;

    cmult_pipe #(
        .DATA_W (DATA_W),
        .TW_W   (TW_W)
    ) u_cmult (
        .clk       (clk),
        .rst_      (rst_),
        .i_en      (w_en),
        .i_inverse (inverse),
        .i_b_re    (b_re),
        .i_b_im    (b_im),
        .i_w_re    (w_re),
        .i_w_im    (w_im),
        .o_t_re    (w_t_re),
        .o_t_im    (w_t_im)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_out_valid <= 1'b0;
            r_a1_re     <= '0;
            r_a1_im     <= '0;
            r_a2_re     <= '0;
            r_a2_im     <= '0;
        end else if (w_en) begin
            r_v1        <= in_valid;
            r_v2        <= r_v1;
            r_out_valid <= r_v2;
            r_a1_re     <= a_re;
            r_a1_im     <= a_im;
            r_a2_re     <= r_a1_re;
            r_a2_im     <= r_a1_im;
        end
    end

    // Sum/difference at DATA_W+2 cannot wrap, so saturation sees the true value.
    always_comb begin
        w_res[0] = OUT_INT_W'(r_a2_re) + w_t_re;
        w_res[1] = OUT_INT_W'(r_a2_im) + w_t_im;
        w_res[2] = OUT_INT_W'(r_a2_re) - w_t_re;
        w_res[3] = OUT_INT_W'(r_a2_im) - w_t_im;
        w_hit    = '0;
        for (int k = 0; k < 4; k++) begin
            if (SCALE != 0) begin
                w_res[k] = w_res[k] >>> 1;
            end
            w_wide[k] = SAT_MAX_W'(w_res[k]);
            w_clip[k] = DATA_W'(sat_clip(w_wide[k], DATA_W));
            w_hit[k]  = (sat_clip(w_wide[k], DATA_W) != w_wide[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_ao_re <= '0;
            r_ao_im <= '0;
            r_bo_re <= '0;
            r_bo_im <= '0;
        end else if (w_en) begin
            r_ao_re <= w_clip[0];
            r_ao_im <= w_clip[1];
            r_bo_re <= w_clip[2];
            r_bo_im <= w_clip[3];
        end
    end

    // A set on the same edge as a clear wins, so no saturation event is ever lost.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_ovf <= 1'b0;
        end else if (w_en && r_v2 && (|w_hit)) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign ao_re     = r_ao_re;
    assign ao_im     = r_ao_im;
    assign bo_re     = r_bo_re;
    assign bo_im     = r_bo_im;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_bfly_r2_pipe.sv
// Bench for bfly_r2_pipe: one SCALE=0 and one SCALE=1 instance share the same stimulus;
// an arithmetic reference model fills per-instance expected queues.
module tb_bfly_r2_pipe;

  localparam int DW = 8;
  localparam int TW = 8;

  logic clk;
  logic rst_;
  logic in_valid;
  logic inverse;
  logic [DW-1:0] a_re, a_im, b_re, b_im;
  logic [TW-1:0] w_re, w_im;
  logic out_ready;
  logic ovf_clr;

  logic in_ready0, out_valid0, ovf0;
  logic in_ready1, out_valid1, ovf1;
  logic [DW-1:0] ao_re0, ao_im0, bo_re0, bo_im0;
  logic [DW-1:0] ao_re1, ao_im1, bo_re1, bo_im1;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out0  = 0;
  int n_out1  = 0;
  logic exp_ovf0 = 1'b0;
  logic exp_ovf1 = 1'b0;
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];

  bfly_r2_pipe #(.DATA_W(DW), .TW_W(TW), .SCALE(0)) dut0 (
    .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_ready(in_ready0), .inverse(inverse),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid0), .out_ready(out_ready),
    .ao_re(ao_re0), .ao_im(ao_im0), .bo_re(bo_re0), .bo_im(bo_im0),
    .ovf(ovf0), .ovf_clr(ovf_clr)
  );

  bfly_r2_pipe #(.DATA_W(DW), .TW_W(TW), .SCALE(1)) dut1 (
    .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_ready(in_ready1), .inverse(inverse),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid1), .out_ready(out_ready),
    .ao_re(ao_re1), .ao_im(ao_im1), .bo_re(bo_re1), .bo_im(bo_im1),
    .ovf(ovf1), .ovf_clr(ovf_clr)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Butterfly from its definition: complex product, round half up, add/sub, scale, clamp.
  function automatic void model(input logic [7:0] ar, ai, br, bi, wr, wi, input logic inv,
                                input int scale, output logic [31:0] res, output bit sat);
    int xar, xai, xbr, xbi, xwr, xwi, tr, ti;
    int v[4];
    xar = int'($signed(ar)); xai = int'($signed(ai));
    xbr = int'($signed(br)); xbi = int'($signed(bi));
    xwr = int'($signed(wr)); xwi = int'($signed(wi));
    if (inv) begin
      tr = xbr * xwr + xbi * xwi;
      ti = xbi * xwr - xbr * xwi;
    end else begin
      tr = xbr * xwr - xbi * xwi;
      ti = xbr * xwi + xbi * xwr;
    end
    tr = (tr + (1 << (TW - 2))) >>> (TW - 1);
    ti = (ti + (1 << (TW - 2))) >>> (TW - 1);
    v[0] = xar + tr; v[1] = xai + ti; v[2] = xar - tr; v[3] = xai - ti;
    sat = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (scale != 0) v[k] = v[k] >>> 1;
      if (v[k] > 127) begin v[k] = 127; sat = 1'b1; end
      else if (v[k] < -128) begin v[k] = -128; sat = 1'b1; end
    end
    res = {8'(v[0]), 8'(v[1]), 8'(v[2]), 8'(v[3])};
  endfunction

  // One cycle: observe handshakes just after the negedge, then advance to the next negedge.
  task automatic tick(output bit acc, output bit ir);
    logic [32:0] e;
    logic [31:0] r;
    bit s;
    #1;
    ir = in_ready0;
    check("in_ready_match", 32'(in_ready1), 32'(in_ready0));
    acc = in_valid && in_ready0;
    if (in_valid && in_ready0) begin
      model(a_re, a_im, b_re, b_im, w_re, w_im, inverse, 0, r, s);
      exp_q0.push_back({s, r});
    end
    if (in_valid && in_ready1) begin
      model(a_re, a_im, b_re, b_im, w_re, w_im, inverse, 1, r, s);
      exp_q1.push_back({s, r});
    end
    if (out_valid0 && out_ready) begin
      if (exp_q0.size() == 0) check("spurious0", 32'(out_valid0), 32'd0);
      else begin
        e = exp_q0.pop_front();
        exp_ovf0 = exp_ovf0 | e[32];
        check("out0", {ao_re0, ao_im0, bo_re0, bo_im0}, e[31:0]);
        check("ovf0", 32'(ovf0), 32'(exp_ovf0));
        n_out0++;
      end
    end
    if (out_valid1 && out_ready) begin
      if (exp_q1.size() == 0) check("spurious1", 32'(out_valid1), 32'd0);
      else begin
        e = exp_q1.pop_front();
        exp_ovf1 = exp_ovf1 | e[32];
        check("out1", {ao_re1, ao_im1, bo_re1, bo_im1}, e[31:0]);
        check("ovf1", 32'(ovf1), 32'(exp_ovf1));
        n_out1++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic one_beat(input string tag, input logic [7:0] ar, ai, br, bi, wr, wi,
                          input logic inv, input logic [31:0] e0,
                          input logic chk1, input logic [31:0] e1);
    bit acc, ir;
    int lat;
    a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
    inverse = inv; in_valid = 1'b1; out_ready = 1'b1;
    tick(acc, ir);
    in_valid = 1'b0;
    check({tag, "_acc"}, 32'(acc), 32'd1);
    lat = 1;
    while (!out_valid0 && lat < 10) begin
      tick(acc, ir);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_out0"}, {ao_re0, ao_im0, bo_re0, bo_im0}, e0);
    if (chk1) check({tag, "_out1"}, {ao_re1, ao_im1, bo_re1, bo_im1}, e1);
    tick(acc, ir);
  endtask

  task automatic clear_ovf();
    bit acc, ir;
    ovf_clr = 1'b1;
    tick(acc, ir);
    ovf_clr = 1'b0;
    exp_ovf0 = 1'b0;
    exp_ovf1 = 1'b0;
  endtask

  initial begin
    bit acc, ir;
    int n0;
    logic [31:0] held;

    rst_ = 1'b0; in_valid = 1'b0; inverse = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("rst_valid", 32'(out_valid0), 32'd0);
    check("rst_out", {ao_re0, ao_im0, bo_re0, bo_im0}, 32'd0);
    check("rst_ovf", 32'(ovf0), 32'd0);
    check("rst_in_ready", 32'(in_ready0), 32'd1);
    rst_ = 1'b1;
    tick(acc, ir);

    // directed vectors
    one_beat("fwd", 8'h40, 8'h00, 8'h20, 8'h00, 8'h7F, 8'h00, 1'b0, 32'h6000_2000, 1'b0, 32'd0);
    check("fwd_ovf", 32'(ovf0), 32'd0);
    one_beat("negj_fwd", 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h80, 1'b0, 32'h00F0_0010, 1'b0, 32'd0);
    one_beat("negj_inv", 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h80, 1'b1, 32'h0010_00F0, 1'b0, 32'd0);
    one_beat("sat", 8'h7F, 8'h00, 8'h7F, 8'h00, 8'h7F, 8'h00, 1'b0, 32'h7F00_0100, 1'b1, 32'h7E00_0000);
    check("sat_ovf0", 32'(ovf0), 32'd1);
    check("sat_ovf1", 32'(ovf1), 32'd0);
    tick(acc, ir); tick(acc, ir);
    check("ovf_sticky", 32'(ovf0), 32'd1);
    clear_ovf();
    check("ovf_cleared", 32'(ovf0), 32'd0);

    // saturating beat reaches the output on the same edge as an ovf_clr pulse
    in_valid = 1'b1;
    tick(acc, ir);
    in_valid = 1'b0;
    tick(acc, ir);
    ovf_clr = 1'b1;
    tick(acc, ir);
    ovf_clr = 1'b0;
    exp_ovf0 = 1'b0;
    exp_ovf1 = 1'b0;
    check("ovf_set_wins", 32'(ovf0), 32'd1);
    tick(acc, ir);
    clear_ovf();

    // backpressure: 6 beats, out_ready low for 4 cycles mid-stream
    n0 = n_out0;
    a_im = 8'h00; b_re = 8'h03; b_im = 8'h01; w_re = 8'h40; w_im = 8'h10; inverse = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      a_re = 8'(i);
      in_valid = 1'b1;
      if (i == 4) begin
        out_ready = 1'b0;
        #1 held = {ao_re0, ao_im0, bo_re0, bo_im0};
        for (int k = 0; k < 4; k++) begin
          tick(acc, ir);
          check("bp_in_ready", 32'(ir), 32'd0);
          check("bp_hold", {ao_re0, ao_im0, bo_re0, bo_im0}, held);
        end
        out_ready = 1'b1;
      end
      acc = 1'b0;
      for (int k = 0; k < 20 && !acc; k++) tick(acc, ir);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20 && exp_q0.size() != 0; k++) tick(acc, ir);
    check("bp_count", 32'(n_out0 - n0), 32'd6);

    // asynchronous reset with beats in flight and ovf set
    one_beat("pre_rst_sat", 8'h7F, 8'h00, 8'h7F, 8'h00, 8'h7F, 8'h00, 1'b0, 32'h7F00_0100, 1'b0, 32'd0);
    a_re = 8'h40; a_im = 8'h00; b_re = 8'h20; b_im = 8'h00; w_re = 8'h7F; w_im = 8'h00;
    in_valid = 1'b1;
    tick(acc, ir); tick(acc, ir);
    in_valid = 1'b0;
    tick(acc, ir);
    check("pre_rst_valid", 32'(out_valid0), 32'd1);
    check("pre_rst_ovf", 32'(ovf0), 32'd1);
    #3 rst_ = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid0), 32'd0);
    check("arst_out", {ao_re0, ao_im0, bo_re0, bo_im0}, 32'd0);
    check("arst_ovf", 32'(ovf0), 32'd0);
    check("arst_valid1", 32'(out_valid1), 32'd0);
    exp_q0.delete();
    exp_q1.delete();
    exp_ovf0 = 1'b0;
    exp_ovf1 = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;
    one_beat("post_rst", 8'h40, 8'h00, 8'h20, 8'h00, 8'h7F, 8'h00, 1'b0, 32'h6000_2000, 1'b0, 32'd0);

    // randomized traffic with random backpressure and mixed modes
    acc = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 9) < 7);
        inverse  = 1'($urandom_range(0, 1));
        a_re = 8'($urandom); a_im = 8'($urandom);
        b_re = 8'($urandom); b_im = 8'($urandom);
        w_re = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
        w_im = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      tick(acc, ir);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && (exp_q0.size() != 0 || exp_q1.size() != 0); k++) tick(acc, ir);
    check("drain0", 32'(exp_q0.size()), 32'd0);
    check("drain1", 32'(exp_q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
